// File: rtl/rr_arb_mux4_pkg.sv
// Shared types and constants for the rr_arb_mux4 round-robin arbiter/mux.
// The optional grant timeout in rr_arb_mux4 is enabled by defining ARB_TIMEOUT_EN.
package rr_arb_mux4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_HOLD_DEF = 16;

  // Select width for an n-way choice; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux4_mux_n_tree.sv
// Parameterized N:1 data mux assembled as a binary tree of 2:1 mux primitives.
// Level l of the tree is steered by select bit l-1 (LSB pairs adjacent inputs).
module mux2 #(
  parameter int DW = 8
) (
  input  logic          sel_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

module mux_n_tree
  import rr_arb_mux4_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int SW = sel_width(N)
) (
  input  logic [SW-1:0]   sel_i,
  input  logic [N*DW-1:0] data_i,
  output logic [DW-1:0]   data_o
);

  for (genvar l = 0; l <= SW; l++) begin : g_lvl
    localparam int W = N >> l;
    logic [W-1:0][DW-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = data_i;
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_mux
        mux2 #(.DW(DW)) u_mux2 (
          .sel_i (sel_i[l-1]),
          .a_i   (g_lvl[l-1].v[2*j]),
          .b_i   (g_lvl[l-1].v[2*j+1]),
          .y_o   (v[j])
        );
      end
    end
  end

  assign data_o = g_lvl[SW].v[0];

endmodule

// File: rtl/rr_arb_mux4.sv
// Round-robin arbiter driving a shared N:1 data mux; registered grant/select.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles when others wait.
module rr_arb_mux4
  import rr_arb_mux4_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 8,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int SW       = sel_width(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [SW-1:0]      o_sel,
  output logic               o_valid,
  output logic [DW-1:0]      o_data
);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic              holder_drop;
  logic              force_rot;
  logic              rearb;
  logic [SW-1:0]     search_base;
  logic [N_REQ-1:0]  search_mask;
  logic              found;
  logic [SW-1:0]     win;
  logic [DW-1:0]     mux_data;

  assign holder_drop = (state_q == ST_GRANT) && !i_req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int HW = sel_width(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;

  assign force_rot = (state_q == ST_GRANT) && i_req[sel_q] &&
                     (hold_q == HW'(MAX_HOLD - 1)) && (|(i_req & ~gnt_q));

  always_comb begin
    hold_d = hold_q;
    if (rearb && found) begin
      hold_d = '0;
    end else if ((state_q == ST_GRANT) && (hold_q != HW'(MAX_HOLD - 1))) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  assign force_rot = 1'b0;
`endif

  // A release (or forced rotation) searches from holder+1 with the holder masked out.
  always_comb begin
    rearb       = 1'b0;
    search_base = ptr_q;
    search_mask = '0;
    if (state_q == ST_IDLE) begin
      rearb       = |i_req;
      search_mask = i_req;
    end else if (holder_drop || force_rot) begin
      rearb       = 1'b1;
      search_base = sel_q + 1'b1;
      search_mask = i_req & ~gnt_q;
    end
  end

  // Rotate so search_base lands at bit 0, find first set, rotate the index back.
  always_comb begin
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    dbl   = {search_mask, search_mask} >> search_base;
    rot   = dbl[N_REQ-1:0];
    found = |rot;
    win   = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (rot[k-1]) win = SW'(k - 1) + search_base;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    if (state_q == ST_GRANT && rearb) ptr_d = sel_q + 1'b1;
    if (rearb) begin
      if (found) begin
        state_d = ST_GRANT;
        sel_d   = win;
        gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  mux_n_tree #(.N(N_REQ), .DW(DW)) u_mux (
    .sel_i  (sel_q),
    .data_i (i_data),
    .data_o (mux_data)
  );

  always_comb begin
    o_valid = (state_q == ST_GRANT);
    o_gnt   = gnt_q;
    o_sel   = sel_q;
    o_data  = o_valid ? mux_data : '0;
  end

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Self-checking bench for rr_arb_mux4 (default build): directed steps plus random traffic.
module tb_rr_arb_mux4;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        valid;
  logic [7:0]  dout;

  int n_assert = 0;
  int n_fail   = 0;

  bit m_valid;
  int m_sel;
  int m_ptr;

  rr_arb_mux4 #(.N_REQ(4), .DW(8), .MAX_HOLD(16)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_req   (req),
    .i_data  (data),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_valid (valid),
    .o_data  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int off = 0; off < 4; off++) begin
      if (r[(start + off) % 4]) return (start + off) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    if (!m_valid) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_sel   = w;
      end
    end else if (!r[m_sel]) begin
      m_ptr = (m_sel + 1) % 4;
      w = pick(r & ~(4'b1 << m_sel), m_ptr);
      if (w >= 0) m_sel = w;
      else        m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] exp_gnt;
    logic [31:0] exp_data;
    exp_gnt  = m_valid ? (32'd1 << m_sel) : 32'd0;
    exp_data = m_valid ? ((data >> (8 * m_sel)) & 32'hFF) : 32'd0;
    check({ctx, ".gnt"}, {28'd0, gnt}, exp_gnt);
    check({ctx, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    check({ctx, ".data"}, {24'd0, dout}, exp_data);
    if (m_valid) check({ctx, ".sel"}, {30'd0, sel}, m_sel);
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    model_step(req);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev;

    rstn = 1'b0;
    req  = 4'b0000;
    data = $urandom;
    model_reset();
    #3;
    check("reset.gnt", {28'd0, gnt}, 32'd0);
    check("reset.sel", {30'd0, sel}, 32'd0);
    check("reset.valid", {31'd0, valid}, 32'd0);
    check("reset.data", {24'd0, dout}, 32'd0);
    #4;
    rstn = 1'b1;

    // Single request with a known data word
    req  = 4'b0100;
    data = 32'h11A5_2233;
    cycle("single");
    check("single.gnt", {28'd0, gnt}, 32'h4);
    check("single.sel", {30'd0, sel}, 32'd2);
    check("single.data", {24'd0, dout}, 32'hA5);
    req = 4'b0000;
    cycle("single_drop");
    check("single_drop.valid", {31'd0, valid}, 32'd0);
    check("single_drop.data", {24'd0, dout}, 32'd0);

    // Asynchronous reset in the middle of a grant
    req = 4'b1111;
    cycle("pre_rst");
    cycle("pre_rst");
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("async_rst.gnt", {28'd0, gnt}, 32'd0);
    check("async_rst.valid", {31'd0, valid}, 32'd0);
    check("async_rst.data", {24'd0, dout}, 32'd0);
    rstn = 1'b1;
    cycle("post_rst");
    check("post_rst.sel", {30'd0, sel}, 32'd0);

    // Fairness: granted requester drops for a cycle, others stay high
    for (int i = 1; i < 5; i++) begin
      req = 4'b1111 & ~(4'b1 << exp_seq[i-1]);
      cycle("fair");
      check("fair.sel", {30'd0, sel}, exp_seq[i]);
      check("fair.valid", {31'd0, valid}, 32'd1);
    end

    // Hold requester 1 while 3 waits, then skip to 3, then back to 0
    req = 4'b0010;
    cycle("hold_start");
    check("hold_start.sel", {30'd0, sel}, 32'd1);
    req = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      data = $urandom;
      cycle("hold");
      check("hold.sel", {30'd0, sel}, 32'd1);
    end
    req = 4'b1000;
    cycle("skip");
    check("skip.sel", {30'd0, sel}, 32'd3);
    req = 4'b0011;
    cycle("wrap");
    check("wrap.sel", {30'd0, sel}, 32'd0);

    // Transient request from 2 while 0 holds is never granted
    req = 4'b0101;
    repeat (2) begin
      cycle("transient");
      check("transient.sel", {30'd0, sel}, 32'd0);
    end
    req = 4'b0001;
    repeat (3) begin
      cycle("transient_gone");
      check("transient_gone.sel", {30'd0, sel}, 32'd0);
    end
    req = 4'b0000;
    cycle("transient_idle");
    check("transient_idle.valid", {31'd0, valid}, 32'd0);

    // Random traffic against the reference model
    prev = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) prev = 4'($urandom_range(0, 15));
      req  = prev;
      data = $urandom;
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
